// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM state
// type and request legality helpers.
package lsu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } lsu_state_t;

    // Legal funct3 encodings differ between loads and stores.
    function automatic logic f3_legal(input logic store, input logic [2:0] f3);
        if (store) begin
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // funct3[1:0] encodes access size for both loads and stores.
    function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   return 1'b1;
            2'b01:   return !lo[0];
            default: return lo == 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_rmw_if.sv
// Core request/response handshake plus the word-addressed memory port.
//   req_*  : core -> LSU request (valid/ready)
//   resp_* : LSU -> core completion pulse, error flag and load data
//   mem_*  : LSU <-> data memory (combinational read, synchronous write)
interface lsu_rmw_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_a, mem_wd
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/lsu_lane.sv
// Byte-lane helper: extracts and extends load data from a memory word, and
// merges store data into that word at the addressed lane (little-endian).
//   word      : memory word read
//   lane      : byte address bits [1:0]
//   funct3    : size in [1:0], zero-extend flag in [2]
//   wdata     : right-aligned store data
//   load_data : extended load result
//   merged    : word with the store bytes replaced
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] mask;

    always_comb begin
        shamt     = {lane, 3'b000};
        shifted   = word >> shamt;
        mask      = 32'h0;
        load_data = word;
        merged    = wdata;
        case (funct3[1:0])
            2'b00: begin
                load_data = funct3[2] ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
                mask      = 32'h0000_00FF << shamt;
                merged    = (word & ~mask) | ((32'(wdata[7:0]) << shamt) & mask);
            end
            2'b01: begin
                load_data = funct3[2] ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
                mask      = 32'h0000_FFFF << shamt;
                merged    = (word & ~mask) | ((32'(wdata[15:0]) << shamt) & mask);
            end
            default: begin
                load_data = word;
                merged    = wdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit converting RV32I loads/stores into whole-word memory
// accesses; sub-word stores are done as read-modify-write.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : request/response handshake and memory port (slave view)
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 64
) (
    input logic       clk,
    input logic       reset,
    lsu_rmw_if.slave  bus
);

    lsu_state_t  state;
    logic        st_store;
    logic [2:0]  st_f3;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;

    logic        accept;
    logic        req_ok;
    logic [31:0] lane_load;
    logic [31:0] lane_merged;

    assign accept = bus.req_valid && bus.req_ready;

    // Legality of the request presented on the accept edge (it is what gets captured).
    assign req_ok = f3_legal(bus.req_store, bus.req_funct3) &&
                    addr_aligned(bus.req_funct3, bus.req_addr[1:0]) &&
                    ({2'b00, bus.req_addr[31:2]} < 32'(MEM_WORDS));

    lsu_lane u_lane (
        .word      (bus.mem_rd),
        .lane      (st_addr[1:0]),
        .funct3    (st_f3),
        .wdata     (st_wdata),
        .load_data (lane_load),
        .merged    (lane_merged)
    );

    // Main FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            st_store       <= 1'b0;
            st_f3          <= 3'b000;
            st_addr        <= 32'h0;
            st_wdata       <= 32'h0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= 32'h0;
            bus.mem_we     <= 1'b0;
            bus.mem_a      <= 32'h0;
            bus.mem_wd     <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        st_store      <= bus.req_store;
                        st_f3         <= bus.req_funct3;
                        st_addr       <= bus.req_addr;
                        st_wdata      <= bus.req_wdata;
                        bus.req_ready <= 1'b0;
                        if (!req_ok) begin
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= 32'h0;
                            state          <= RESP;
                        end else begin
                            // mem_a only follows legal requests so it never leaves the array.
                            bus.mem_a <= {2'b00, bus.req_addr[31:2]};
                            // SW needs no read, so its write goes out in ACCESS.
                            if (bus.req_store && (bus.req_funct3 == F3_SW)) begin
                                bus.mem_we <= 1'b1;
                                bus.mem_wd <= bus.req_wdata;
                            end
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!st_store) begin
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b0;
                        bus.resp_rdata <= lane_load;
                        state          <= RESP;
                    end else if (st_f3 == F3_SW) begin
                        bus.mem_we     <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b0;
                        bus.resp_rdata <= 32'h0;
                        state          <= RESP;
                    end else begin
                        bus.mem_we <= 1'b1;
                        bus.mem_wd <= lane_merged;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    bus.mem_we     <= 1'b0;
                    bus.resp_valid <= 1'b1;
                    bus.resp_err   <= 1'b0;
                    bus.resp_rdata <= 32'h0;
                    state          <= RESP;
                end
                RESP: begin
                    bus.resp_valid <= 1'b0;
                    bus.req_ready  <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_rmw.sv
// Self-checking bench for lsu_rmw: directed cases, reset abort and randomized
// requests checked against a byte-level reference model of the memory.
module tb_lsu_rmw;

    localparam int unsigned MEM_WORDS = 64;

    logic clk = 1'b0;
    logic reset;
    logic mem_init_done;

    lsu_rmw_if bus ();

    lsu_rmw #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Data memory attached to the DUT.
    logic [31:0] mem [MEM_WORDS];
    // Reference copy of what the memory should contain.
    logic [31:0] ref_mem [MEM_WORDS];

    assign bus.mem_rd = (bus.mem_a < 32'(MEM_WORDS)) ? mem[bus.mem_a[5:0]] : 32'h0;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < int'(MEM_WORDS); i++)
                mem[i] <= (i == 8) ? 32'h0002_3BFF : 32'h0;
        end else if (bus.mem_we && (bus.mem_a < 32'(MEM_WORDS))) begin
            mem[bus.mem_a[5:0]] <= bus.mem_wd;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Reference model: byte-wise view of memory per RV32I rules.
    task automatic model(input logic store, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                         output int lat, output int we_cyc, output logic [31:0] new_word);
        int size;
        int lane;
        int widx;
        logic legal;
        logic [31:0] w;
        size  = 1 << f3[1:0];
        legal = store ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        err   = !legal || ((addr % 32'(size)) != 0) || ((addr >> 2) >= 32'(MEM_WORDS));
        rdata = 32'h0;
        we_cyc = 0;
        new_word = 32'h0;
        if (err) begin
            lat = 1;
        end else begin
            widx = int'(addr >> 2);
            lane = int'(addr % 4);
            w    = ref_mem[widx];
            if (!store) begin
                lat = 2;
                for (int i = 0; i < size; i++)
                    rdata |= ((w >> (8 * (lane + i))) & 32'hFF) << (8 * i);
                if (!f3[2] && size < 4 && rdata[8 * size - 1])
                    rdata |= 32'hFFFF_FFFF << (8 * size);
            end else begin
                lat    = (size == 4) ? 2 : 3;
                we_cyc = lat - 1;
                for (int i = 0; i < size; i++)
                    w = (w & ~(32'hFF << (8 * (lane + i)))) |
                        (((wdata >> (8 * i)) & 32'hFF) << (8 * (lane + i)));
                new_word = w;
                ref_mem[widx] = w;
            end
        end
    endtask

    // Issue one request at a negedge, follow it to completion and score it.
    task automatic do_req(input string tag, input logic store, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] got_rd);
        logic e_err, g_err, seen;
        logic [31:0] e_rd, e_word, we_a, we_d;
        int e_lat, e_we, lat, we_cyc, we_count;
        model(store, f3, addr, wdata, e_err, e_rd, e_lat, e_we, e_word);
        check({tag, ":ready_in"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_store  = store;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk);
        #1;
        // Garbage while busy must be ignored.
        bus.req_valid  = 1'($urandom_range(0, 1));
        bus.req_store  = 1'($urandom_range(0, 1));
        bus.req_funct3 = 3'($urandom_range(0, 7));
        bus.req_addr   = $urandom();
        bus.req_wdata  = $urandom();
        seen = 1'b0; lat = 0; we_cyc = 0; we_count = 0;
        we_a = 32'h0; we_d = 32'h0; g_err = 1'b0; got_rd = 32'h0;
        for (int k = 1; k <= 6 && !seen; k++) begin
            @(negedge clk);
            if (bus.mem_we) begin
                we_count++; we_cyc = k; we_a = bus.mem_a; we_d = bus.mem_wd;
            end
            if (bus.resp_valid) begin
                seen = 1'b1; lat = k; g_err = bus.resp_err; got_rd = bus.resp_rdata;
                check({tag, ":ready_resp"}, 32'(bus.req_ready), 32'd0);
            end
        end
        bus.req_valid = 1'b0;
        check({tag, ":resp_seen"}, 32'(seen), 32'd1);
        check({tag, ":lat"}, 32'(lat), 32'(e_lat));
        check({tag, ":err"}, 32'(g_err), 32'(e_err));
        check({tag, ":rdata"}, got_rd, e_rd);
        check({tag, ":we_count"}, 32'(we_count), (e_we != 0) ? 32'd1 : 32'd0);
        check({tag, ":we_cyc"}, 32'(we_cyc), 32'(e_we));
        if (e_we != 0) begin
            check({tag, ":we_a"}, we_a, addr >> 2);
            check({tag, ":we_d"}, we_d, e_word);
        end
        @(negedge clk);
        check({tag, ":pulse_end"}, 32'(bus.resp_valid), 32'd0);
        check({tag, ":ready_back"}, 32'(bus.req_ready), 32'd1);
    endtask

    task automatic compare_mem(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < int'(MEM_WORDS); i++)
            if (mem[i] !== ref_mem[i]) bad++;
        check(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;

        for (int i = 0; i < int'(MEM_WORDS); i++)
            ref_mem[i] = (i == 8) ? 32'h0002_3BFF : 32'h0;
        mem_init_done  = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst:ready", 32'(bus.req_ready), 32'd1);
        check("rst:resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst:resp_err", 32'(bus.resp_err), 32'd0);
        check("rst:resp_rdata", bus.resp_rdata, 32'h0);
        check("rst:mem_we", 32'(bus.mem_we), 32'd0);
        check("rst:mem_a", bus.mem_a, 32'h0);
        check("rst:mem_wd", bus.mem_wd, 32'h0);
        @(posedge clk);
        #1 mem_init_done = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        compare_mem("preload");

        // Reset during the WRITE phase of an SH abandons the write.
        bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'b001;
        bus.req_addr = 32'h20; bus.req_wdata = 32'h0000_1234;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort:we_in_write", 32'(bus.mem_we), 32'd1);
        reset = 1'b1;
        #1;
        check("abort:mem_we", 32'(bus.mem_we), 32'd0);
        check("abort:ready", 32'(bus.req_ready), 32'd1);
        check("abort:resp_valid", 32'(bus.resp_valid), 32'd0);
        check("abort:mem_a", bus.mem_a, 32'h0);
        check("abort:mem_wd", bus.mem_wd, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort:no_resp", 32'(bus.resp_valid), 32'd0);
        end
        check("abort:ready_after", 32'(bus.req_ready), 32'd1);
        check("abort:word8", mem[8], 32'h0002_3BFF);

        // Directed cases.
        do_req("lb21",  1'b0, 3'b000, 32'h21, 32'h0, rd); check("lb21:lit", rd, 32'h0000_003B);
        do_req("lb20",  1'b0, 3'b000, 32'h20, 32'h0, rd); check("lb20:lit", rd, 32'hFFFF_FFFF);
        do_req("lbu20", 1'b0, 3'b100, 32'h20, 32'h0, rd); check("lbu20:lit", rd, 32'h0000_00FF);
        do_req("lh22",  1'b0, 3'b001, 32'h22, 32'h0, rd); check("lh22:lit", rd, 32'h0000_0002);
        do_req("sb21",  1'b1, 3'b000, 32'h21, 32'h1234_56AA, rd);
        check("sb21:mem", mem[8], 32'h0002_AAFF);
        do_req("lw20",  1'b0, 3'b010, 32'h20, 32'h0, rd); check("lw20:lit", rd, 32'h0002_AAFF);
        do_req("sw24",  1'b1, 3'b010, 32'h24, 32'hDEAD_BEEF, rd);
        do_req("lw24",  1'b0, 3'b010, 32'h24, 32'h0, rd); check("lw24:lit", rd, 32'hDEAD_BEEF);
        do_req("lw22_mis",  1'b0, 3'b010, 32'h22, 32'h0, rd);
        do_req("sh23_mis",  1'b1, 3'b001, 32'h23, 32'hFFFF_FFFF, rd);
        do_req("ld011_ill", 1'b0, 3'b011, 32'h20, 32'h0, rd);
        do_req("lw100_oor", 1'b0, 3'b010, 32'h100, 32'h0, rd);
        do_req("sw_oor",    1'b1, 3'b010, 32'hFC0, 32'h5555_5555, rd);
        do_req("lhu_hi",    1'b0, 3'b101, 32'hFE, 32'h0, rd);
        compare_mem("directed_mem");

        // Randomized requests.
        for (int n = 0; n < 250; n++) begin
            st = 1'($urandom_range(0, 1));
            f3 = st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0)
                a = $urandom();
            else
                a = 32'($urandom_range(0, 4 * int'(MEM_WORDS) + 31));
            do_req("rand", st, f3, a, $urandom(), rd);
        end
        compare_mem("final_mem");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
